booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational signed 8x8 `booth` multiplier among `NREQ` requesters. It sits between the requesters and the single `booth` instance:
- It accepts one operand pair at a time over a valid/ready handshake.
- It holds the operands stable on the multiplier inputs for a full cycle, registers the 16-bit product, and returns it with the requester's ID over a valid/ready response port.

---
 rtl/booth_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational signed 8x8 booth multiplier.
// Optional feature macro: BOOTH_ARB_STATS_EN adds the op_count response counter port.
module booth_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [15:0]       resp_product,
    output logic [7:0]        mul_multiplier,
    output logic [7:0]        mul_multiplicand,
    input  logic [15:0]       mul_product
`ifdef BOOTH_ARB_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] id;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic           grant_found;
    logic           take;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    int             cand;

    // Search starts just after the previous winner so every waiting requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[IDW-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign take = (state == IDLE) && grant_found && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = CALC;
                end
            end
            CALC: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are only loaded at a grant, so the multiplier inputs stay quiet between jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            id           <= '0;
            last_grant   <= IDW'(NREQ - 1);
            resp_product <= '0;
            resp_id      <= '0;
        end else begin
            if (take) begin
                op_a       <= req_a[{grant_idx, 3'b000} +: 8];
                op_b       <= req_b[{grant_idx, 3'b000} +: 8];
                id         <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == CALC) begin
                resp_product <= mul_product;
                resp_id      <= id;
            end
        end
    end

    assign mul_multiplier   = op_a;
    assign mul_multiplicand = op_b;

`ifdef BOOTH_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (resp_valid && resp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: transaction-level model plus directed literal checks.
// Define BOOTH_ARB_STATS_EN for both files to exercise the op_count counter.
module tb_booth_mul_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [15:0]       resp_product;
    logic [7:0]        mul_multiplier;
    logic [7:0]        mul_multiplicand;
    logic [15:0]       mul_product;
`ifdef BOOTH_ARB_STATS_EN
    logic [15:0]       op_count;
`endif

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    int          grant_log[$];
    int          resp_id_log[$];
    logic [15:0] resp_prod_log[$];

    booth_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_id         (resp_id),
        .resp_product    (resp_product),
        .mul_multiplier  (mul_multiplier),
        .mul_multiplicand(mul_multiplicand),
        .mul_product     (mul_product)
`ifdef BOOTH_ARB_STATS_EN
        ,
        .op_count        (op_count)
`endif
    );

    // Stand-in for the external booth multiplier.
    assign mul_product = 16'($signed(mul_multiplier) * $signed(mul_multiplicand));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Transaction-level model: one job in flight, result visible two cycles after the grant.
    bit               m_inflight;
    int               m_age;
    int               m_last;
    int               m_id;
    logic [7:0]       m_a;
    logic [7:0]       m_b;
    logic signed [15:0] m_prod;
    logic [15:0]      m_resp_prod;
    logic [IDW-1:0]   m_resp_id;
    logic [15:0]      m_count;

    always @(posedge clk) begin : model
        int g;
        cyc++;
        if (rst) begin
            m_inflight  = 1'b0;
            m_age       = 0;
            m_last      = NREQ - 1;
            m_a         = '0;
            m_b         = '0;
            m_resp_prod = '0;
            m_resp_id   = '0;
            m_count     = '0;
        end else if (!m_inflight) begin
            g = pick(req_valid, m_last);
            if (g >= 0) begin
                m_inflight = 1'b1;
                m_age      = 1;
                m_id       = g;
                m_a        = req_a[g*8 +: 8];
                m_b        = req_b[g*8 +: 8];
                m_prod     = $signed(m_a) * $signed(m_b);
                m_last     = g;
            end
        end else if (m_age < 2) begin
            m_age       = 2;
            m_resp_prod = m_prod;
            m_resp_id   = IDW'(m_id);
        end else if (resp_ready) begin
            m_inflight = 1'b0;
            m_count    = m_count + 16'd1;
        end
    end

    always @(negedge clk) begin : compare
        logic [NREQ-1:0] er;
        int g;
        if (check_en) begin
            er = '0;
            if (!rst && !m_inflight) begin
                g = pick(req_valid, m_last);
                if (g >= 0) er[g] = 1'b1;
            end
            checkOutput("req_ready", 32'(req_ready), 32'(er));
            checkOutput("resp_valid", 32'(resp_valid), 32'(m_inflight && m_age == 2));
            checkOutput("resp_id", 32'(resp_id), 32'(m_resp_id));
            checkOutput("resp_product", 32'(resp_product), 32'(m_resp_prod));
            checkOutput("mul_multiplier", 32'(mul_multiplier), 32'(m_a));
            checkOutput("mul_multiplicand", 32'(mul_multiplicand), 32'(m_b));
`ifdef BOOTH_ARB_STATS_EN
            checkOutput("op_count", 32'(op_count), 32'(m_count));
`endif
            if (!rst) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) grant_log.push_back(i);
                end
            end
            if (resp_valid && resp_ready) begin
                resp_id_log.push_back(int'(resp_id));
                resp_prod_log.push_back(resp_product);
            end
        end
    end

    task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b, output int gcyc);
        @(posedge clk);
        #1;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_valid[i]    = 1'b1;
        gcyc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            total++;
            $display("[TB] FAIL grant_timeout: requester %0d got no req_ready within 50 cycles", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic waitResp(output int rcyc);
        rcyc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                rcyc = cyc;
                break;
            end
        end
        if (rcyc < 0) begin
            total++;
            $display("[TB] FAIL resp_timeout: no resp_valid within 50 cycles");
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : stimulus
        int g;
        int r;
        int pulses;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset state, including no grant while rst is high.
        @(posedge clk);
        #1 check_en = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_resp_product", 32'(resp_product), 32'h0);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b0;

        // Single op: 1*1 from requester 0.
        applyStimulus(0, 8'd1, 8'd1, g);
        waitResp(r);
        checkOutput("t1_latency", 32'(r - g), 32'd2);
        checkOutput("t1_id", 32'(resp_id), 32'd0);
        checkOutput("t1_product", 32'(resp_product), 32'h0001);

        // Signed operands: -2 * -80 = 160.
        applyStimulus(2, 8'hFE, 8'hB0, g);
        waitResp(r);
        checkOutput("t2_latency", 32'(r - g), 32'd2);
        checkOutput("t2_id", 32'(resp_id), 32'd2);
        checkOutput("t2_product", 32'(resp_product), 32'h00A0);

        // Contention: everyone valid continuously from reset.
        pulseReset();
        req_a = {8'h07, 8'h80, 8'd21, 8'd95};
        req_b = {8'hFD, 8'h80, 8'h8F, 8'd84};
        grant_log.delete();
        resp_id_log.delete();
        resp_prod_log.delete();
        req_valid = 4'hF;
        repeat (16) @(posedge clk);
        #1 req_valid = '0;
        repeat (6) @(posedge clk);
        checkOutput("t3_grant_count", 32'(grant_log.size() >= 5), 32'd1);
        checkOutput("t3_resp_count", 32'(resp_prod_log.size() >= 5), 32'd1);
        if (grant_log.size() >= 5 && resp_prod_log.size() >= 5) begin
            checkOutput("t3_grant0", 32'(grant_log[0]), 32'd0);
            checkOutput("t3_grant1", 32'(grant_log[1]), 32'd1);
            checkOutput("t3_grant2", 32'(grant_log[2]), 32'd2);
            checkOutput("t3_grant3", 32'(grant_log[3]), 32'd3);
            checkOutput("t3_grant4", 32'(grant_log[4]), 32'd0);
            checkOutput("t3_prod0", 32'(resp_prod_log[0]), 32'h1F2C);
            checkOutput("t3_prod1", 32'(resp_prod_log[1]), 32'hF6BB);
            checkOutput("t3_prod2", 32'(resp_prod_log[2]), 32'h4000);
            checkOutput("t3_prod3", 32'(resp_prod_log[3]), 32'hFFEB);
            checkOutput("t3_prod4", 32'(resp_prod_log[4]), 32'h1F2C);
            checkOutput("t3_id2", 32'(resp_id_log[2]), 32'd2);
        end

        // Backpressure: 5 stalled cycles in RESP, requester 3 waiting meanwhile.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        applyStimulus(1, 8'd5, 8'd6, g);
        req_a[31:24]  = 8'd2;
        req_b[31:24]  = 8'hFF;
        req_valid[3]  = 1'b1;
        waitResp(r);
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            checkOutput("t4_stall_valid", 32'(resp_valid), 32'd1);
            checkOutput("t4_stall_id", 32'(resp_id), 32'd1);
            checkOutput("t4_stall_product", 32'(resp_product), 32'h001E);
            if (req_ready != '0) pulses++;
        end
        checkOutput("t4_no_grant_in_stall", 32'(pulses), 32'd0);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_next_grant", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        waitResp(r);
        checkOutput("t4_id", 32'(resp_id), 32'd3);
        checkOutput("t4_product", 32'(resp_product), 32'hFFFE);

        // Reset while in CALC: result dropped, pointer back to requester 0.
        applyStimulus(0, 8'd3, 8'd3, g);
        rst = 1'b1;
        req_a[7:0]  = 8'd4;
        req_b[7:0]  = 8'd4;
        req_a[15:8] = 8'd2;
        req_b[15:8] = 8'd2;
        req_valid   = 4'b0011;
        resp_id_log.delete();
        resp_prod_log.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("t5_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        applyStimulus(1, 8'd2, 8'd2, g);
        waitResp(r);
        @(posedge clk);
        #1;
        checkOutput("t5_resp_count", 32'(resp_prod_log.size()), 32'd2);
        if (resp_prod_log.size() >= 2) begin
            checkOutput("t5_first_id", 32'(resp_id_log[0]), 32'd0);
            checkOutput("t5_first_product", 32'(resp_prod_log[0]), 32'h0010);
            checkOutput("t5_second_product", 32'(resp_prod_log[1]), 32'h0004);
        end

`ifdef BOOTH_ARB_STATS_EN
        // Counter: three handshakes, then wrap from 16'hFFFF.
        pulseReset();
        for (int t = 0; t < 3; t++) begin
            applyStimulus(t, 8'd1, 8'd2, g);
            waitResp(r);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stats_count3", 32'(op_count), 32'd3);
        @(posedge clk);
        #1;
        force dut.op_count = 16'hFFFF;
        m_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.op_count;
        applyStimulus(3, 8'd1, 8'd1, g);
        waitResp(r);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stats_wrap", 32'(op_count), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
